// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS instruction/data bus arbiter.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } bus_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam logic [3:0] BYTEEN_ALL = 4'b1111;

    // Everything the arbiter presents on the memory master port, kept together
    // so it can be registered and cleared as one unit.
    typedef struct packed {
        logic [31:0] address;
        logic        read;
        logic        write;
        logic [31:0] writedata;
        logic [3:0]  byteenable;
    } bus_cmd_t;

    localparam bus_cmd_t CMD_IDLE = '0;

    // Instruction fetches are always full-word reads with no write data.
    function automatic bus_cmd_t fetchCmd(input logic [31:0] addr);
        bus_cmd_t cmd;
        cmd            = CMD_IDLE;
        cmd.address    = addr;
        cmd.read       = 1'b1;
        cmd.byteenable = BYTEEN_ALL;
        return cmd;
    endfunction

    // Data accesses carry the requester's fields through; exactly one strobe is set.
    function automatic bus_cmd_t dataCmd(input logic        isWrite,
                                         input logic [31:0] addr,
                                         input logic [31:0] wdata,
                                         input logic [3:0]  byteen);
        bus_cmd_t cmd;
        cmd.address    = addr;
        cmd.read       = ~isWrite;
        cmd.write      = isWrite;
        cmd.writedata  = wdata;
        cmd.byteenable = byteen;
        return cmd;
    endfunction

endpackage

// File: rtl/mips_bus_wait_timer.sv
// Counts waitrequest-stalled cycles of one transfer and flags when the limit is hit.
module mips_bus_wait_timer
    import mips_bus_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    // A zero limit disables the timeout; the counter still needs a legal width.
    localparam int LIMIT = (MAX_WAIT > 0) ? MAX_WAIT : 1;
    localparam int CW    = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] C_LIMIT = CW'(LIMIT);

    logic [CW-1:0] r_count;

    // Saturating stall counter, restarted whenever the arbiter is not holding a grant.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (count_en && (r_count != C_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (MAX_WAIT > 0) && (r_count == C_LIMIT);

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single waitrequest-style memory master.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteen,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        bus_err
);

    bus_state_t  r_state, w_nextState;
    grant_t      r_lastGrant, w_nextLastGrant;
    bus_cmd_t    r_cmd, w_nextCmd;
    logic [31:0] r_iRdata, w_nextIRdata;
    logic [31:0] r_dRdata, w_nextDRdata;
    logic        r_iDone, w_nextIDone;
    logic        r_dDone, w_nextDDone;
    logic        r_busErr, w_nextBusErr;

    logic w_iEligible, w_dEligible, w_pickD;
    logic w_inGrant, w_complete, w_timeout;
    logic w_timerClear, w_timerCount, w_expired;

    // A requester is deaf during its own done cycle so a held req is not re-granted.
    assign w_iEligible = i_req & ~r_iDone;
    assign w_dEligible = d_req & ~r_dDone;
    assign w_pickD     = w_dEligible & (~w_iEligible | (r_lastGrant == GRANT_I));

    assign w_inGrant  = (r_state != IDLE);
    assign w_complete = w_inGrant & (r_cmd.read | r_cmd.write) & ~waitrequest;
    assign w_timeout  = w_inGrant & waitrequest & w_expired;

    assign w_timerClear = ~w_inGrant;
    assign w_timerCount = w_inGrant & waitrequest;

    mips_bus_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_waitTimer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_timerClear),
        .count_en(w_timerCount),
        .expired (w_expired)
    );

    // Next-state, next master command and requester results; a real completion
    // takes priority over a timeout that lands on the same edge.
    always_comb begin
        w_nextState     = r_state;
        w_nextLastGrant = r_lastGrant;
        w_nextCmd       = r_cmd;
        w_nextIRdata    = r_iRdata;
        w_nextDRdata    = r_dRdata;
        w_nextIDone     = 1'b0;
        w_nextDDone     = 1'b0;
        w_nextBusErr    = r_busErr;

        case (r_state)
            IDLE: begin
                w_nextCmd = CMD_IDLE;
                if (w_pickD) begin
                    w_nextState     = GNT_D;
                    w_nextLastGrant = GRANT_D;
                    w_nextCmd       = dataCmd(d_write, d_addr, d_wdata, d_byteen);
                end else if (w_iEligible) begin
                    w_nextState     = GNT_I;
                    w_nextLastGrant = GRANT_I;
                    w_nextCmd       = fetchCmd(i_addr);
                end
            end
            GNT_I: begin
                if (w_complete) begin
                    w_nextIRdata = readdata;
                    w_nextIDone  = 1'b1;
                    w_nextState  = IDLE;
                    w_nextCmd    = CMD_IDLE;
                end else if (w_timeout) begin
                    w_nextIRdata = '0;
                    w_nextIDone  = 1'b1;
                    w_nextBusErr = 1'b1;
                    w_nextState  = IDLE;
                    w_nextCmd    = CMD_IDLE;
                end
            end
            GNT_D: begin
                if (w_complete) begin
                    if (r_cmd.read) begin
                        w_nextDRdata = readdata;
                    end
                    w_nextDDone = 1'b1;
                    w_nextState = IDLE;
                    w_nextCmd   = CMD_IDLE;
                end else if (w_timeout) begin
                    w_nextDRdata = '0;
                    w_nextDDone  = 1'b1;
                    w_nextBusErr = 1'b1;
                    w_nextState  = IDLE;
                    w_nextCmd    = CMD_IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCmd   = CMD_IDLE;
            end
        endcase
    end

    // State and every output register; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lastGrant <= GRANT_I;
            r_cmd       <= CMD_IDLE;
            r_iRdata    <= '0;
            r_dRdata    <= '0;
            r_iDone     <= 1'b0;
            r_dDone     <= 1'b0;
            r_busErr    <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_lastGrant <= w_nextLastGrant;
            r_cmd       <= w_nextCmd;
            r_iRdata    <= w_nextIRdata;
            r_dRdata    <= w_nextDRdata;
            r_iDone     <= w_nextIDone;
            r_dDone     <= w_nextDDone;
            r_busErr    <= w_nextBusErr;
        end
    end

    assign address    = r_cmd.address;
    assign read       = r_cmd.read;
    assign write      = r_cmd.write;
    assign writedata  = r_cmd.writedata;
    assign byteenable = r_cmd.byteenable;
    assign i_rdata    = r_iRdata;
    assign i_done     = r_iDone;
    assign d_rdata    = r_dRdata;
    assign d_done     = r_dDone;
    assign busy       = w_inGrant;
    assign bus_err    = r_busErr;

endmodule
